// File: rtl/rs232in_fifo_pkg.sv
// Shared definitions for the rs232in receive FIFO: default geometry and
// the per-cycle operation encoding used by the pointer/count update logic.
package rs232in_fifo_pkg;

    localparam int DEFAULT_DEPTH_LOG2 = 4;
    localparam int DEFAULT_RTS_MARGIN = 4;

    // Width of the fill count that the rs232 block exposes as register 2.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e op_decode(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/rs232in_fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port and one
// asynchronous read port, contents deliberately not reset.
module rs232in_fifo_ram #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rs232in_fifo.sv
// First-word-fall-through receive FIFO between rs232in and the rs232 register
// block. Define RS232IN_FIFO_RTS_EN to drive nrts from the fill level.
module rs232in_fifo
    import rs232in_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int RTS_MARGIN = DEFAULT_RTS_MARGIN
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_attention,
    input  logic [7:0]            in_data,
    input  logic                  pop,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  nrts
);

    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = count_width(DEPTH_LOG2);
    localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(2**DEPTH_LOG2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    if (RTS_MARGIN < 1 || RTS_MARGIN > 2**DEPTH_LOG2) begin : g_bad_margin
        $error("rs232in_fifo: RTS_MARGIN must be within 1..2**DEPTH_LOG2");
    end

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop, drop;
    fifo_op_e         op;
    logic [7:0]       ram_rdata;

    // A pop on a full FIFO frees the slot the incoming byte lands in.
    assign do_push = in_attention & (~full_q | pop);
    assign do_pop  = pop & ~empty_q;
    assign drop    = in_attention & full_q & ~pop;
    assign op      = op_decode(do_push, do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        case (op)
            OP_PUSH: begin
                wptr_d  = wptr_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end
            OP_POP: begin
                rptr_d  = rptr_q + PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
            OP_BOTH: begin
                wptr_d = wptr_q + PTR_ONE;
                rptr_d = rptr_q + PTR_ONE;
            end
            default: ;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH);
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    rs232in_fifo_ram #(
        .ADDR_W (PTR_W)
    ) u_ram (
        .clock (clock),
        .we    (do_push),
        .waddr (wptr_q),
        .wdata (in_data),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

`ifdef RS232IN_FIFO_RTS_EN
    localparam logic [CNT_W-1:0] RTS_THRESH = CNT_W'(2**DEPTH_LOG2 - RTS_MARGIN);

    logic nrts_q, nrts_d;

    // Compared against the registered count, so nrts trails it by one cycle.
    always_comb begin
        nrts_d = (count_q >= RTS_THRESH);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            nrts_q <= 1'b0;
        end else begin
            nrts_q <= nrts_d;
        end
    end

    assign nrts = nrts_q;
`else
    assign nrts = 1'b0;
`endif

    assign rd_data  = empty_q ? 8'h00 : ram_rdata;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rs232in_fifo.sv
// Directed self-checking bench for rs232in_fifo (default geometry, 16 bytes).
module tb_rs232in_fifo;

`ifdef RS232IN_FIFO_RTS_EN
    localparam bit RTS = 1'b1;
`else
    localparam bit RTS = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst_n;
    logic       in_attention;
    logic [7:0] in_data;
    logic       pop;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       clr_overflow;
    logic       nrts;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rs232in_fifo dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .in_attention (in_attention),
        .in_data      (in_data),
        .pop          (pop),
        .rd_data      (rd_data),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .nrts         (nrts)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic att, input logic [7:0] d, input logic p, input logic clr);
        in_attention = att;
        in_data      = d;
        pop          = p;
        clr_overflow = clr;
        @(posedge clock);
        #1;
        in_attention = 1'b0;
        in_data      = 8'h00;
        pop          = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"},    32'(count),    32'd0);
        chk({tag, "_empty"},    32'(empty),    32'd1);
        chk({tag, "_full"},     32'(full),     32'd0);
        chk({tag, "_rd_data"},  32'(rd_data),  32'h00);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_nrts"},     32'(nrts),     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain_exp [16];
        int         c_before;

        rst_n        = 1'b0;
        in_attention = 1'b0;
        in_data      = 8'h00;
        pop          = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Three spaced strobes, then pops.
        repeat (9) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("first_count", 32'(count), 32'd1);
        chk("first_rd",    32'(rd_data), 32'h41);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        chk("three_count", 32'(count), 32'd3);
        chk("three_rd",    32'(rd_data), 32'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop1_rd", 32'(rd_data), 32'h42);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop2_rd", 32'(rd_data), 32'h43);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop3_empty", 32'(empty), 32'd1);
        chk("pop3_rd",    32'(rd_data), 32'h00);
        chk("pop3_count", 32'(count), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_on_empty_count", 32'(count), 32'd0);

        // Push and pop together on an empty FIFO: the pop is ignored.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("empty_both_count", 32'(count), 32'd1);
        chk("empty_both_rd",    32'(rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_both_drain", 32'(empty), 32'd1);

        // Fill to 16, watching the RTS threshold at 12.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 11) begin
                chk("nrts_at_12_same", 32'(nrts), 32'd0);
                step(1'b0, 8'h00, 1'b0, 1'b0);
                chk("nrts_at_12_next", 32'(nrts), 32'(RTS));
            end
        end
        chk("fill_full",     32'(full), 32'd1);
        chk("fill_count",    32'(count), 32'd16);
        chk("fill_overflow", 32'(overflow), 32'd0);
        chk("fill_rd",       32'(rd_data), 32'h00);

        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_count",    32'(count), 32'd16);

        // Set beats clear in the same cycle.
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("set_wins_overflow", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clear_overflow", 32'(overflow), 32'd0);

        // Push and pop together on a full FIFO.
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_both_count",    32'(count), 32'd16);
        chk("full_both_overflow", 32'(overflow), 32'd0);
        chk("full_both_full",     32'(full), 32'd1);

        for (int j = 0; j < 15; j++) drain_exp[j] = 8'(j + 1);
        drain_exp[15] = 8'hAA;
        for (int j = 0; j < 16; j++) begin
            c_before = 16 - j;
            chk($sformatf("drain_rd_%0d", j), 32'(rd_data), 32'(drain_exp[j]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain_nrts_%0d", j), 32'(nrts), 32'(RTS && (c_before >= 12)));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rd0",   32'(rd_data), 32'h00);
        chk("drain_count", 32'(count), 32'd0);

        // Interleaved push/pop across several pointer wraps.
        step(1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("wrap_rd_%0d", k), 32'(rd_data), 32'(k));
            step(1'b1, 8'(k + 1), 1'b1, 1'b0);
            chk($sformatf("wrap_count_%0d", k), 32'(count), 32'd1);
        end
        chk("wrap_last_rd", 32'(rd_data), 32'd40);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of a fill.
        for (int i = 0; i < 13; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("midfill_count", 32'(count), 32'd13);
        chk("midfill_nrts",  32'(nrts), 32'(RTS));
        in_attention = 1'b1;
        in_data      = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        in_attention = 1'b0;
        @(posedge clock);
        #1;
        chk_reset_outputs("held_reset");
        rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_reset_count", 32'(count), 32'd1);
        chk("post_reset_rd",    32'(rd_data), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs232in_fifo.md
# rs232in_fifo

Receive buffer between the `rs232in` deserializer and the `rs232` peripheral register block. Captures every byte announced by the `rs232in` single-cycle `attention` strobe into a first-word-fall-through FIFO, so that bursts at 115 200 bps are not lost while software is slow to poll. The `rs232` block reads the head byte (register 1) and the fill count (register 2) from this block instead of directly from `rs232in`. Optionally drives the board's `ser_nrts` pin for hardware flow control.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO holds 2^DEPTH_LOG2 bytes.
- `RTS_MARGIN`, 4: free-slot threshold for deasserting RTS; must be 1..2^DEPTH_LOG2.

Ports:
- `clock`  in  1  system clock (PLL output, 80 MHz).
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_attention`  in  1  one-cycle strobe from `rs232in`: `in_data` valid.
- `in_data`  in  8  received byte.
- `pop`  in  1  consume head byte; ignored when `empty`.
- `rd_data`  out  8  head byte, valid while `empty` = 0; 8'h00 when empty.
- `count`  out  DEPTH_LOG2+1  bytes held, 0..2^DEPTH_LOG2.
- `empty`  out  1  `count` == 0.
- `full`  out  1  `count` == 2^DEPTH_LOG2.
- `overflow`  out  1  sticky: a byte was dropped.
- `clr_overflow`  in  1  clears `overflow`.
- `nrts`  out  1  active-low request-to-send to the host.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 array; write pointer `wptr`, read pointer `rptr`, each DEPTH_LOG2 bits, wrap modulo 2^DEPTH_LOG2; separate `count` register (no pointer-compare full/empty).
- Push = `in_attention` & (~`full` | `pop`). Pop = `pop` & ~`empty`.
- Push: mem[wptr] <= in_data, wptr++. Pop: rptr++. `count` += push - pop.
- Push and pop in the same cycle when full: both occur, `count` unchanged, no overflow.
- Push and pop in the same cycle when empty: pop ignored, byte stored, `count` = 1.
- `in_attention` when full and no pop: byte discarded, `overflow` <= 1.
- `overflow`: set wins over `clr_overflow` in the same cycle; otherwise `clr_overflow` clears it.
- `rd_data` = mem[rptr] gated by ~`empty` (combinational from array and registered `rptr`).
- Reset, asserted at any time including mid-burst: pointers, `count`, `overflow` to 0; `empty`=1, `full`=0, `rd_data`=8'h00, `nrts`=0. Array contents are not reset and are never observable.

## Timing
- Byte strobed in cycle N: `count`/`empty` update at the edge ending N; `rd_data` valid in N+1.
- `pop` in cycle N: next byte (or empty) visible in N+1; back-to-back pops allowed every cycle.
- `empty`, `full`, `count` are registered; no combinational path from `in_attention` to any output.
- `rd_data` is combinational from `pop` only through registered `rptr`; no path from `pop` in the same cycle.
- `nrts` registered, one cycle after `count` crosses the threshold.

## Configuration
- `RS232IN_FIFO_RTS_EN` defined: `nrts` <= 1 (stop) when `count` >= 2^DEPTH_LOG2 - RTS_MARGIN, else 0; the comparison uses the registered `count`.
- Undefined: `nrts` is constant 0 (host always allowed to send); threshold logic absent; `RTS_MARGIN` unused.

## Structure
- Shared header `rs232in_fifo.h`: default `DEPTH_LOG2`, `RTS_MARGIN`, and the `count` width macro used by `rs232` for register 2.
- Sub-module `fifo_ram`: 2^DEPTH_LOG2 x 8 array, one synchronous write port, one asynchronous read port; maps to LEs/M4K on the EP1C12.
- Top-level `main` instantiates this block between `rs232in_inst` and `rs232_inst`; `ser_nrts` driven from `nrts`.

## Test plan
- Reset, then strobe 8'h41, 8'h42, 8'h43 on cycles 10, 12, 14 -> `count` 3, `rd_data` 8'h41; three pops -> 8'h42, 8'h43, then `empty`=1, `rd_data`=8'h00.
- Push 16 bytes 8'h00..8'h0F (DEPTH_LOG2=4) -> `full`=1, `count`=16; 17th strobe 8'hFF -> dropped, `overflow`=1; drain returns 8'h00..8'h0F in order.
- Full FIFO, `in_attention` and `pop` same cycle with 8'hAA -> `count` stays 16, `overflow` 0, 8'hAA read last.
- `overflow` set, `clr_overflow` and a dropping strobe in the same cycle -> `overflow` stays 1; `clr_overflow` alone next cycle -> 0.
- Wrap: 40 interleaved push/pop of incrementing bytes -> output sequence identical to input, `count` never exceeds 2.
- With `RS232IN_FIFO_RTS_EN`, fill to 12 -> `nrts`=1 one cycle after the 12th push; pop to 11 -> `nrts`=0; assert `rst_n`=0 mid-fill -> all outputs at reset values immediately.
